// File: rtl/demux_pkg.sv
// Shared types for the 1-to-2 packet stream demux: FSM state encoding and
// the width of the optional egress counters.
package demux_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOCK0 = 2'd1,
    LOCK1 = 2'd2
  } demux_state_t;

  localparam int DEMUX_COUNT_W = 16;
  localparam int NUM_OUT       = 2;

  function automatic demux_state_t lock_of(input logic sel);
    return sel ? LOCK1 : LOCK0;
  endfunction

endpackage

// File: rtl/stream_slot.sv
// One-entry registered valid/ready stage; loads a new beat in the same cycle
// the held beat drains, so a steady stream passes at full rate.
module stream_slot #(
  parameter int WIDTH = 64
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_last
);

  logic             valid_q, valid_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic             last_q, last_d;

  assign in_ready  = !valid_q || out_ready;
  assign out_valid = valid_q;
  assign out_data  = data_q;
  assign out_last  = last_q;

  // Payload only changes on a load, so it stays stable while stalled.
  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    last_d  = last_q;
    if (in_valid && in_ready) begin
      valid_d = 1'b1;
      data_d  = in_data;
      last_d  = in_last;
    end else if (out_ready) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid_q <= 1'b0;
      data_q  <= '0;
      last_q  <= 1'b0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
      last_q  <= last_d;
    end
  end

endmodule

// File: rtl/stream_demux_1to2.sv
// Packet-aware 1-to-2 stream demux: in_sel on a packet's first beat locks the
// destination until in_last. Define DEMUX_STATS_EN to add per-output counters.
module stream_demux_1to2
  import demux_pkg::*;
#(
  parameter int WIDTH = 64
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_sel,
  input  logic             in_last,
  output logic             out0_valid,
  input  logic             out0_ready,
  output logic [WIDTH-1:0] out0_data,
  output logic             out0_last,
  output logic             out1_valid,
  input  logic             out1_ready,
  output logic [WIDTH-1:0] out1_data,
  output logic             out1_last
`ifdef DEMUX_STATS_EN
  ,
  output logic [DEMUX_COUNT_W-1:0] out0_count,
  output logic [DEMUX_COUNT_W-1:0] out1_count
`endif
);

  demux_state_t state_q, state_d;
  logic         tgt;
  logic         accept;

  logic [NUM_OUT-1:0]            s_in_valid;
  logic [NUM_OUT-1:0]            s_in_ready;
  logic [NUM_OUT-1:0]            s_out_valid;
  logic [NUM_OUT-1:0]            s_out_ready;
  logic [NUM_OUT-1:0]            s_out_last;
  logic [NUM_OUT-1:0][WIDTH-1:0] s_out_data;

  always_comb begin
    tgt = in_sel;
    case (state_q)
      LOCK0:   tgt = 1'b0;
      LOCK1:   tgt = 1'b1;
      default: tgt = in_sel;
    endcase
  end

  // Ready looks only at the target slot and its sink, never at in_valid.
  assign in_ready = !reset && s_in_ready[tgt];
  assign accept   = in_valid && in_ready;

  always_comb begin
    state_d = state_q;
    if (accept) begin
      if (in_last)             state_d = IDLE;
      else if (state_q == IDLE) state_d = lock_of(in_sel);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  assign s_out_ready = {out1_ready, out0_ready};

  for (genvar g = 0; g < NUM_OUT; g++) begin : g_slot
    assign s_in_valid[g] = accept && (tgt == 1'(g));
    stream_slot #(.WIDTH(WIDTH)) u_slot (
      .clk       (clk),
      .reset     (reset),
      .in_valid  (s_in_valid[g]),
      .in_ready  (s_in_ready[g]),
      .in_data   (in_data),
      .in_last   (in_last),
      .out_valid (s_out_valid[g]),
      .out_ready (s_out_ready[g]),
      .out_data  (s_out_data[g]),
      .out_last  (s_out_last[g])
    );
  end

  assign out0_valid = s_out_valid[0];
  assign out0_data  = s_out_data[0];
  assign out0_last  = s_out_last[0];
  assign out1_valid = s_out_valid[1];
  assign out1_data  = s_out_data[1];
  assign out1_last  = s_out_last[1];

`ifdef DEMUX_STATS_EN
  logic [NUM_OUT-1:0][DEMUX_COUNT_W-1:0] cnt_q, cnt_d;

  // Counters wrap naturally at their width.
  always_comb begin
    cnt_d = cnt_q;
    for (int i = 0; i < NUM_OUT; i++)
      if (s_out_valid[i] && s_out_ready[i]) cnt_d[i] = cnt_q[i] + 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign out0_count = cnt_q[0];
  assign out1_count = cnt_q[1];
`endif

endmodule

// File: tb/tb_stream_demux_1to2.sv
// Directed scenarios plus a randomized run scored against a packet-level
// reference model (per-output FIFOs and a current-packet destination).
module tb_stream_demux_1to2;

  localparam int WIDTH = 64;

  logic             clk = 1'b0;
  logic             reset;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             in_sel;
  logic             in_last;
  logic             out0_valid, out0_ready, out0_last;
  logic [WIDTH-1:0] out0_data;
  logic             out1_valid, out1_ready, out1_last;
  logic [WIDTH-1:0] out1_data;
`ifdef DEMUX_STATS_EN
  logic [15:0]      out0_count, out1_count;
`endif

  int pass_cnt = 0;
  int total_cnt = 0;

  always #5 clk = ~clk;

  stream_demux_1to2 #(.WIDTH(WIDTH)) dut (
    .clk        (clk),
    .reset      (reset),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .in_sel     (in_sel),
    .in_last    (in_last),
    .out0_valid (out0_valid),
    .out0_ready (out0_ready),
    .out0_data  (out0_data),
    .out0_last  (out0_last),
    .out1_valid (out1_valid),
    .out1_ready (out1_ready),
    .out1_data  (out1_data),
    .out1_last  (out1_last)
`ifdef DEMUX_STATS_EN
    ,
    .out0_count (out0_count),
    .out1_count (out1_count)
`endif
  );

  // Advance one clock; inputs are always driven on the falling edge.
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic drive(input logic v, input logic s, input logic l, input logic [WIDTH-1:0] d);
    in_valid = v; in_sel = s; in_last = l; in_data = d;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    drive(0, 0, 0, '0);
    tick();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    reset = 1'b1;
    drive(1, 0, 0, 64'h1);
    out0_ready = 1'b1; out1_ready = 1'b1;
    #1;
    total_cnt++;
    if (in_ready !== 1'b0) $display("FAIL reset_in_ready got %0b exp 0", in_ready); else pass_cnt++;
    total_cnt++;
    if ({out0_valid, out1_valid} !== 2'b00) $display("FAIL reset_valid got %b exp 00", {out0_valid, out1_valid}); else pass_cnt++;
    total_cnt++;
    if ({out0_data, out1_data, out0_last, out1_last} !== '0)
      $display("FAIL reset_payload got %h/%h exp 0", out0_data, out1_data);
    else pass_cnt++;
    tick();
    drive(0, 0, 0, '0);
    reset = 1'b0;
  endtask

  task automatic test_single_beat();
    out0_ready = 1'b1; out1_ready = 1'b1;
    drive(1, 1, 1, 64'hA5);
    #1;
    total_cnt++;
    if (in_ready !== 1'b1) $display("FAIL single_in_ready got %0b exp 1", in_ready); else pass_cnt++;
    tick();
    drive(0, 0, 0, '0);
    total_cnt++;
    if ({out1_valid, out1_data, out1_last, out0_valid} !== {1'b1, 64'hA5, 1'b1, 1'b0})
      $display("FAIL single_out got v1=%0b d=%h l=%0b v0=%0b exp 1/a5/1/0", out1_valid, out1_data, out1_last, out0_valid);
    else pass_cnt++;
    tick();
    // State returned to IDLE: a fresh sel=0 beat must go to out0.
    drive(1, 0, 1, 64'h5A);
    tick();
    drive(0, 0, 0, '0);
    total_cnt++;
    if ({out0_valid, out0_data, out1_valid} !== {1'b1, 64'h5A, 1'b0})
      $display("FAIL single_idle got v0=%0b d=%h v1=%0b exp 1/5a/0", out0_valid, out0_data, out1_valid);
    else pass_cnt++;
    tick();
  endtask

  task automatic test_lock();
    logic [3:0] sels;
    sels = 4'b1010;
    out0_ready = 1'b1; out1_ready = 1'b1;
    for (int i = 0; i <= 4; i++) begin
      if (i > 0) begin
        total_cnt++;
        if ({out0_valid, out0_data, out0_last, out1_valid} !== {1'b1, 64'(i), (i == 4), 1'b0})
          $display("FAIL lock_beat%0d got v0=%0b d=%h l=%0b v1=%0b exp 1/%h/%0b/0",
                   i, out0_valid, out0_data, out0_last, out1_valid, 64'(i), (i == 4));
        else pass_cnt++;
      end
      if (i < 4) drive(1, sels[i], (i == 3), 64'(i + 1));
      else       drive(0, 0, 0, '0);
      tick();
    end
  endtask

  task automatic test_backpressure();
    out0_ready = 1'b0; out1_ready = 1'b1;
    drive(1, 0, 0, 64'h11);
    #1;
    total_cnt++;
    if (in_ready !== 1'b1) $display("FAIL bp_first_ready got %0b exp 1", in_ready); else pass_cnt++;
    tick();
    drive(1, 1, 1, 64'h22);
    #1;
    total_cnt++;
    if ({in_ready, out0_valid, out0_data} !== {1'b0, 1'b1, 64'h11})
      $display("FAIL bp_stall got rdy=%0b v=%0b d=%h exp 0/1/11", in_ready, out0_valid, out0_data);
    else pass_cnt++;
    tick();
    total_cnt++;
    if ({in_ready, out0_data, out0_last} !== {1'b0, 64'h11, 1'b0})
      $display("FAIL bp_hold got rdy=%0b d=%h l=%0b exp 0/11/0", in_ready, out0_data, out0_last);
    else pass_cnt++;
    out0_ready = 1'b1;
    #1;
    total_cnt++;
    if (in_ready !== 1'b1) $display("FAIL bp_drain_ready got %0b exp 1", in_ready); else pass_cnt++;
    tick();
    drive(0, 0, 0, '0);
    total_cnt++;
    if ({out0_valid, out0_data, out0_last, out1_valid} !== {1'b1, 64'h22, 1'b1, 1'b0})
      $display("FAIL bp_second got v=%0b d=%h l=%0b v1=%0b exp 1/22/1/0", out0_valid, out0_data, out0_last, out1_valid);
    else pass_cnt++;
    tick();
    total_cnt++;
    if (out0_valid !== 1'b0) $display("FAIL bp_empty got %0b exp 0", out0_valid); else pass_cnt++;
  endtask

  task automatic test_independence();
    out0_ready = 1'b0; out1_ready = 1'b1;
    drive(1, 0, 1, 64'h33);
    tick();
    drive(1, 1, 1, 64'h44);
    #1;
    total_cnt++;
    if (in_ready !== 1'b1) $display("FAIL indep_ready got %0b exp 1", in_ready); else pass_cnt++;
    tick();
    drive(0, 0, 0, '0);
    total_cnt++;
    if ({out1_valid, out1_data, out0_valid, out0_data} !== {1'b1, 64'h44, 1'b1, 64'h33})
      $display("FAIL indep_out got v1=%0b d1=%h v0=%0b d0=%h exp 1/44/1/33", out1_valid, out1_data, out0_valid, out0_data);
    else pass_cnt++;
    out0_ready = 1'b1;
    tick();
    tick();
  endtask

  task automatic test_reset_mid_packet();
    out0_ready = 1'b1; out1_ready = 1'b0;
    drive(1, 1, 0, 64'h61);
    tick();
    out1_ready = 1'b1;
    drive(1, 0, 0, 64'h62);
    tick();
    drive(0, 0, 0, '0);
    out1_ready = 1'b0;
    reset = 1'b1;
    #1;
    total_cnt++;
    if ({out1_valid, in_ready} !== 2'b00)
      $display("FAIL rstmid_clear got v1=%0b rdy=%0b exp 0/0", out1_valid, in_ready);
    else pass_cnt++;
    tick();
    reset = 1'b0;
    drive(1, 0, 1, 64'h55);
    tick();
    drive(0, 0, 0, '0);
    total_cnt++;
    if ({out0_valid, out0_data, out1_valid} !== {1'b1, 64'h55, 1'b0})
      $display("FAIL rstmid_route got v0=%0b d=%h v1=%0b exp 1/55/0", out0_valid, out0_data, out1_valid);
    else pass_cnt++;
    out1_ready = 1'b1;
    tick();
  endtask

  task automatic test_random();
    logic [WIDTH:0] expq [2][$];
    int             lock;
    int             t;
    logic           ov [2], ordy [2], ol [2];
    logic [WIDTH-1:0] od [2];
    logic [WIDTH:0] e;
    do_reset();
    lock = -1;
    for (int c = 0; c < 3000; c++) begin
      drive(($urandom_range(0, 9) < 7), $urandom_range(0, 1), ($urandom_range(0, 9) < 3),
            {$urandom, $urandom});
      out0_ready = ($urandom_range(0, 9) < 6);
      out1_ready = ($urandom_range(0, 9) < 8);
      #1;
      ov[0] = out0_valid; ordy[0] = out0_ready; od[0] = out0_data; ol[0] = out0_last;
      ov[1] = out1_valid; ordy[1] = out1_ready; od[1] = out1_data; ol[1] = out1_last;
      t = (lock < 0) ? int'(in_sel) : lock;
      total_cnt++;
      if (in_ready !== ((expq[t].size() == 0) || ordy[t]))
        $display("FAIL rand_ready cyc%0d got %0b exp %0b", c, in_ready, ((expq[t].size() == 0) || ordy[t]));
      else pass_cnt++;
      for (int k = 0; k < 2; k++) begin
        total_cnt++;
        if (ov[k] !== (expq[k].size() != 0))
          $display("FAIL rand_valid%0d cyc%0d got %0b exp %0b", k, c, ov[k], (expq[k].size() != 0));
        else pass_cnt++;
        if (ov[k] === 1'b1 && expq[k].size() != 0) begin
          e = expq[k][0];
          total_cnt++;
          if ({ol[k], od[k]} !== e)
            $display("FAIL rand_data%0d cyc%0d got %0b/%h exp %0b/%h", k, c, ol[k], od[k], e[WIDTH], e[WIDTH-1:0]);
          else pass_cnt++;
          if (ordy[k]) void'(expq[k].pop_front());
        end
      end
      if (in_valid && in_ready) begin
        expq[t].push_back({in_last, in_data});
        lock = in_last ? -1 : t;
      end
      tick();
    end
    drive(0, 0, 0, '0);
    out0_ready = 1'b1; out1_ready = 1'b1;
    tick();
    tick();
  endtask

`ifdef DEMUX_STATS_EN
  task automatic test_stats();
    logic [15:0] c0, c1;
    c0 = out0_count; c1 = out1_count;
    out0_ready = 1'b1; out1_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      drive(1, 0, 1, 64'(i));
      tick();
    end
    drive(0, 0, 0, '0);
    tick();
    tick();
    total_cnt++;
    if ({out0_count, out1_count} !== {16'(c0 + 16'd3), c1})
      $display("FAIL stats_count got %h/%h exp %h/%h", out0_count, out1_count, 16'(c0 + 16'd3), c1);
    else pass_cnt++;
    out1_ready = 1'b1;
  endtask
`endif

  initial begin
    reset = 1'b1;
    drive(0, 0, 0, '0);
    out0_ready = 1'b0; out1_ready = 1'b0;
    test_reset();
    test_single_beat();
    test_lock();
    test_backpressure();
    test_independence();
    test_reset_mid_packet();
`ifdef DEMUX_STATS_EN
    test_stats();
`endif
    test_random();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/stream_demux_1to2.md
STREAM_DEMUX_1TO2 -- requirements
Module: stream_demux_1to2

Interface
REQ-001 SHALL have parameter: WIDTH, 64, data beat width in bits.
REQ-002 SHALL have port: clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port: reset  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port: in_valid  input  1  ingress beat present.
REQ-005 SHALL have port: in_ready  output  1  ingress beat accepted when in_valid & in_ready.
REQ-006 SHALL have port: in_data  input  WIDTH  ingress payload.
REQ-007 SHALL have port: in_sel  input  1  destination select (0 -> out0, 1 -> out1); sampled only on a packet's first beat.
REQ-008 SHALL have port: in_last  input  1  final beat of packet.
REQ-009 SHALL have ports: out0_valid / out1_valid  output  1  egress beat present.
REQ-010 SHALL have ports: out0_ready / out1_ready  input  1  egress sink accepts.
REQ-011 SHALL have ports: out0_data / out1_data  output  WIDTH  egress payload.
REQ-012 SHALL have ports: out0_last / out1_last  output  1  egress last flag.

Function
REQ-013 SHALL route each accepted ingress beat, unmodified (data and last), to exactly one output.
REQ-014 SHALL implement FSM states IDLE, LOCK0, LOCK1.
REQ-015 IDLE: accepted beat with in_last=0 -> LOCK0 if in_sel=0, LOCK1 if in_sel=1; accepted beat with in_last=1 -> remain IDLE (single-beat packet).
REQ-016 LOCK0/LOCK1: every accepted beat goes to the locked output regardless of in_sel; accepted beat with in_last=1 -> IDLE.
REQ-017 SHALL hold exactly one registered entry per output; a beat is visible on outN_valid the cycle after acceptance (latency 1).
REQ-018 in_ready SHALL be 1 iff the target slot is empty, or full and draining this cycle (outN_valid & outN_ready); target = in_sel in IDLE, locked output otherwise.
REQ-019 Full slot with simultaneous drain and accept SHALL load the new beat with no bubble (100% throughput per output).
REQ-020 Non-target output SHALL hold or drain independently; a stalled output SHALL NOT block a packet destined to the other output.
REQ-021 outN_data/outN_last SHALL be stable while outN_valid=1 and outN_ready=0.
REQ-022 in_ready SHALL NOT depend on in_valid (no combinational valid->ready loop).

Reset
REQ-023 On reset assertion (asynchronous): state=IDLE, out0_valid=out1_valid=0, outN_data=0, outN_last=0, counters=0.
REQ-024 Reset mid-packet SHALL discard slot contents and lock; first beat after reset is treated as a new packet's first beat.
REQ-025 in_ready SHALL be 0 while reset is asserted.

Configuration
REQ-026 Macro DEMUX_STATS_EN defined: SHALL add output ports out0_count, out1_count (16 bits each), incremented on every egress handshake of that output, wrapping 0xFFFF -> 0x0000.
REQ-027 Macro DEMUX_STATS_EN undefined: count ports and counter logic SHALL be absent; all other behaviour identical.

Structure
REQ-028 Shared package demux_pkg SHALL hold the state typedef demux_state_t (IDLE, LOCK0, LOCK1) and constant DEMUX_COUNT_W=16.
REQ-029 The one-entry egress register SHALL be sub-module stream_slot (valid/ready/data/last in and out), instantiated twice.

Verification
REQ-030 Single beat: reset, in_sel=1, in_last=1, in_data=0xA5 one cycle, out1_ready=1 -> out1_valid=1 with 0xA5/last=1 next cycle; out0_valid stays 0; state IDLE.
REQ-031 Lock: 4-beat packet in_sel=0 on beat 0, in_sel toggled on beats 1-3, data 1..4 -> all four on out0 in order, last only on beat 4; out1 untouched.
REQ-032 Backpressure: out0_ready=0, send two beats to out0 -> first accepted, in_ready=0 afterwards; data held stable; raise out0_ready -> second accepted same cycle as first drains.
REQ-033 Independence: out0 stalled with full slot, single-beat packet to out1 -> accepted and delivered to out1 within 1 cycle.
REQ-034 Reset mid-packet: assert reset after beat 2 of 4 to out1 -> out1_valid=0 immediately; next beat with in_sel=0 routes to out0.
REQ-035 With DEMUX_STATS_EN: preload 0xFFFE deliveries (or force), deliver 3 beats to out0 -> out0_count=0x0001; out1_count unchanged.
